// File: rtl/pol2rec_iter_pkg.sv
// Shared constants and types for the CORDIC polar-to-rectangular converter.
//   - state_e      : controller states
//   - DEG90        : 90.0 degrees in signed 8Q24
//   - INV_GAIN_1Q31: 1/K for N_ITER >= 16, unsigned 1Q31
//   - atan_deg()   : atan(2^-i) in degrees, signed 8Q24, i = 0..29
package pol2rec_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int                ATAN_ENTRIES  = 30;
  localparam logic signed [31:0] DEG90        = 32'sh5A00_0000;
  localparam logic [31:0]       INV_GAIN_1Q31 = 32'h4DBA_76D4;

  function automatic logic [31:0] atan_deg(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_deg = 32'h2D00_0000;
      5'd1:  atan_deg = 32'h1A90_A732;
      5'd2:  atan_deg = 32'h0E09_4740;
      5'd3:  atan_deg = 32'h0720_0112;
      5'd4:  atan_deg = 32'h0393_8AA6;
      5'd5:  atan_deg = 32'h01CA_3795;
      5'd6:  atan_deg = 32'h00E5_2A1B;
      5'd7:  atan_deg = 32'h0072_96D8;
      5'd8:  atan_deg = 32'h0039_4BA5;
      5'd9:  atan_deg = 32'h001C_A5DA;
      5'd10: atan_deg = 32'h000E_52EE;
      5'd11: atan_deg = 32'h0007_2977;
      5'd12: atan_deg = 32'h0003_94BC;
      5'd13: atan_deg = 32'h0001_CA5E;
      5'd14: atan_deg = 32'h0000_E52F;
      5'd15: atan_deg = 32'h0000_7297;
      5'd16: atan_deg = 32'h0000_394C;
      5'd17: atan_deg = 32'h0000_1CA6;
      5'd18: atan_deg = 32'h0000_0E53;
      5'd19: atan_deg = 32'h0000_0729;
      5'd20: atan_deg = 32'h0000_0395;
      5'd21: atan_deg = 32'h0000_01CA;
      5'd22: atan_deg = 32'h0000_00E5;
      5'd23: atan_deg = 32'h0000_0073;
      5'd24: atan_deg = 32'h0000_0039;
      5'd25: atan_deg = 32'h0000_001D;
      5'd26: atan_deg = 32'h0000_000E;
      5'd27: atan_deg = 32'h0000_0007;
      5'd28: atan_deg = 32'h0000_0004;
      5'd29: atan_deg = 32'h0000_0002;
      default: atan_deg = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/pol2rec_iter_if.sv
// Handshake and operand/result bundle for pol2rec_iter.
//   start       : request (master -> slave)
//   mod, angle  : polar operand, 16Q16 modulus and 8Q24 degrees
//   busy, done  : status (slave -> master), done is a one-cycle pulse
//   x, y        : rectangular result, 16Q16
interface pol2rec_iter_if;
  logic        start;
  logic [31:0] mod;
  logic [31:0] angle;
  logic        busy;
  logic        done;
  logic [31:0] x;
  logic [31:0] y;

  modport master (output start, mod, angle, input busy, done, x, y);
  modport slave  (input start, mod, angle, output busy, done, x, y);
endinterface

// File: rtl/pol2rec_iter_atan_rom.sv
// Combinational micro-rotation angle lookup, shared with the rec2pol path.
//   idx_i  : iteration index
//   atan_o : atan(2^-idx) in degrees, signed 8Q24
module pol2rec_iter_atan_rom
  import pol2rec_iter_pkg::*;
(
  input  logic [4:0]  idx_i,
  output logic [31:0] atan_o
);
  assign atan_o = atan_deg(idx_i);
endmodule

// File: rtl/pol2rec_iter.sv
// Iterative rotation-mode CORDIC: polar (16Q16 modulus, 8Q24 degrees) to
// rectangular (16Q16). One micro-rotation per enabled clock.
//   clock_i  : system clock, rising edge
//   reset_i  : synchronous active-high reset, overrides enable
//   enable_i : clock enable; low freezes every register
//   bus      : start/mod/angle in, busy/done/x/y out
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands captured on acceptance
// LOAD    | gain prescale and quadrant fold into x/y/z
// ITER    | N_ITER micro-rotations; results registered on the last one
// DONE    | done pulse cycle, results valid; returns to IDLE
module pol2rec_iter
  import pol2rec_iter_pkg::*;
#(
  parameter int          N_ITER   = 24,
  parameter int          GUARD    = 2,
  parameter logic [31:0] INV_GAIN = INV_GAIN_1Q31
) (
  input logic             clock_i,
  input logic             reset_i,
  input logic             enable_i,
  pol2rec_iter_if.slave   bus
);

  localparam int                 XW        = 32 + GUARD;
  localparam logic [4:0]         I_LAST    = 5'(N_ITER - 1);
  localparam logic signed [31:0] NEG_DEG90 = -DEG90;

  state_e                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic [31:0]             x_q;
  logic [31:0]             y_q;
  logic [31:0]             mod_q;
  logic signed [31:0]      angle_q;
  logic signed [XW-1:0]    xr_q;
  logic signed [XW-1:0]    yr_q;
  logic signed [31:0]      z_q;
  logic [4:0]              i_q;

  logic signed [63:0]      prod;
  logic signed [XW-1:0]    m_s;
  logic signed [XW-1:0]    x0_d;
  logic signed [XW-1:0]    y0_d;
  logic signed [31:0]      z0_d;
  logic [31:0]             atan_i;
  logic signed [XW-1:0]    x_sh;
  logic signed [XW-1:0]    y_sh;
  logic signed [XW-1:0]    x_d;
  logic signed [XW-1:0]    y_d;
  logic signed [31:0]      z_d;
  logic [31:0]             x_sat;
  logic [31:0]             y_sat;

  pol2rec_iter_atan_rom u_atan_rom (
    .idx_i  (i_q),
    .atan_o (atan_i)
  );

  // Gain is below 2^31, so zero-extending it keeps the product signed-correct.
  assign prod = $signed({{32{mod_q[31]}}, mod_q}) * $signed({32'd0, INV_GAIN});
  assign m_s  = XW'(prod >>> 31);

  // Angles beyond +/-90 are pre-rotated by +/-90 so the residual stays
  // inside the CORDIC convergence range.
  always_comb begin
    x0_d = m_s;
    y0_d = '0;
    z0_d = angle_q;
    if (angle_q > DEG90) begin
      x0_d = '0;
      y0_d = m_s;
      z0_d = angle_q - DEG90;
    end else if (angle_q < NEG_DEG90) begin
      x0_d = '0;
      y0_d = -m_s;
      z0_d = angle_q + DEG90;
    end
  end

  assign x_sh = xr_q >>> i_q;
  assign y_sh = yr_q >>> i_q;

  always_comb begin
    if (!z_q[31]) begin
      x_d = xr_q - y_sh;
      y_d = yr_q + x_sh;
      z_d = z_q - $signed(atan_i);
    end else begin
      x_d = xr_q + y_sh;
      y_d = yr_q - x_sh;
      z_d = z_q + $signed(atan_i);
    end
  end

  // In range when all bits from 31 upward agree with the sign.
  always_comb begin
    if (&x_d[XW-1:31] || ~|x_d[XW-1:31]) x_sat = x_d[31:0];
    else                                 x_sat = x_d[XW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (&y_d[XW-1:31] || ~|y_d[XW-1:31]) y_sat = y_d[31:0];
    else                                 y_sat = y_d[XW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      mod_q   <= '0;
      angle_q <= '0;
      xr_q    <= '0;
      yr_q    <= '0;
      z_q     <= '0;
      i_q     <= '0;
    end else if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mod_q   <= bus.mod;
            angle_q <= bus.angle;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          xr_q    <= x0_d;
          yr_q    <= y0_d;
          z_q     <= z0_d;
          i_q     <= '0;
          state_q <= ST_ITER;
        end
        ST_ITER: begin
          xr_q <= x_d;
          yr_q <= y_d;
          z_q  <= z_d;
          i_q  <= i_q + 5'd1;
          // Outputs are registered on the final rotation so the DONE cycle
          // already presents valid x/y alongside the done pulse.
          if (i_q == I_LAST) begin
            x_q     <= x_sat;
            y_q     <= y_sat;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.x    = x_q;
  assign bus.y    = y_q;

endmodule

// File: tb/tb_pol2rec_iter.sv
module tb_pol2rec_iter;

  logic clk;
  logic rst;
  logic en;
  int   n_assert;
  int   n_fail;
  int   cyc;
  int   busy_cnt;
  int   extra_done;

  pol2rec_iter_if bus ();

  pol2rec_iter dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .enable_i (en),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    int  diff;
    logic ok;
    diff = $signed(obs) - $signed(exp);
    ok   = (diff >= -8) && (diff <= 8);
    n_assert++;
    assert (ok === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h+/-8", tag, obs, exp);
    end
  endtask

  // Starts one conversion and waits for done. cyc counts negedges after the
  // accepting edge (-1 on timeout); busy_cnt counts negedges with busy high.
  task automatic run_op(input logic [31:0] m, input logic [31:0] a,
                        input int stall_at, input int stall_len, input int pulse_at,
                        output int cyc_o, output int busy_o);
    @(negedge clk);
    bus.mod   = m;
    bus.angle = a;
    bus.start = 1'b1;
    @(posedge clk);
    cyc_o  = -1;
    busy_o = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.start = (k == pulse_at);
      if (k == stall_at) en = 1'b0;
      if (stall_len > 0 && k == stall_at + stall_len) en = 1'b1;
      if (bus.busy) busy_o++;
      if (bus.done) begin
        cyc_o = k;
        break;
      end
    end
    bus.start = 1'b0;
    en        = 1'b1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    en        = 1'b1;
    bus.start = 1'b0;
    bus.mod   = '0;
    bus.angle = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("reset_done", {31'd0, bus.done}, 32'd0);
    check_eq("reset_x", bus.x, 32'd0);
    check_eq("reset_y", bus.y, 32'd0);
    rst = 1'b0;

    // 1.0 at 0 degrees: latency and busy span
    run_op(32'h0001_0000, 32'h0000_0000, 0, 0, 0, cyc, busy_cnt);
    check_eq("a0_latency", cyc, 32'd26);
    check_eq("a0_busy_cycles", busy_cnt, 32'd25);
    check_near("a0_x", bus.x, 32'h0001_0000);
    check_near("a0_y", bus.y, 32'h0000_0000);
    @(negedge clk);
    check_eq("a0_done_width", {31'd0, bus.done}, 32'd0);
    check_near("a0_x_hold", bus.x, 32'h0001_0000);

    // 2.0 at exactly +90 (unfolded)
    run_op(32'h0002_0000, 32'h5A00_0000, 0, 0, 0, cyc, busy_cnt);
    check_eq("p90_latency", cyc, 32'd26);
    check_near("p90_x", bus.x, 32'h0000_0000);
    check_near("p90_y", bus.y, 32'h0002_0000);
    @(negedge clk);

    // 2.0 at exactly -90 (unfolded)
    run_op(32'h0002_0000, 32'hA600_0000, 0, 0, 0, cyc, busy_cnt);
    check_near("m90_x", bus.x, 32'h0000_0000);
    check_near("m90_y", bus.y, 32'hFFFE_0000);
    @(negedge clk);

    // 1.0 at 45; then a start raised during the DONE cycle must be ignored
    run_op(32'h0001_0000, 32'h2D00_0000, 0, 0, 0, cyc, busy_cnt);
    check_near("a45_x", bus.x, 32'h0000_B505);
    check_near("a45_y", bus.y, 32'h0000_B505);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("start_in_done_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check_eq("start_in_done_busy2", {31'd0, bus.busy}, 32'd0);

    // 1.0 at +120 (folded): cos = -0.5, sin = 0.866
    run_op(32'h0001_0000, 32'h7800_0000, 0, 0, 0, cyc, busy_cnt);
    check_near("p120_x", bus.x, 32'hFFFF_8000);
    check_near("p120_y", bus.y, 32'h0000_DDB4);
    @(negedge clk);

    // 1.0 at -120 (folded negative)
    run_op(32'h0001_0000, 32'h8800_0000, 0, 0, 0, cyc, busy_cnt);
    check_near("m120_x", bus.x, 32'hFFFF_8000);
    check_near("m120_y", bus.y, 32'hFFFF_224C);
    @(negedge clk);

    // negative modulus: point rotated by 180
    run_op(32'hFFFF_0000, 32'h0000_0000, 0, 0, 0, cyc, busy_cnt);
    check_near("negmod_x", bus.x, 32'hFFFF_0000);
    check_near("negmod_y", bus.y, 32'h0000_0000);
    @(negedge clk);

    // 5-cycle enable stall mid-iteration plus a start pulse while busy
    run_op(32'h0001_0000, 32'h2D00_0000, 10, 5, 5, cyc, busy_cnt);
    check_eq("stall_latency", cyc, 32'd31);
    check_eq("stall_busy_cycles", busy_cnt, 32'd30);
    check_near("stall_x", bus.x, 32'h0000_B505);
    check_near("stall_y", bus.y, 32'h0000_B505);
    extra_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check_eq("start_while_busy_extra_done", extra_done, 32'd0);
    check_eq("start_while_busy_idle", {31'd0, bus.busy}, 32'd0);

    // reset in the middle of ITER
    @(negedge clk);
    bus.mod   = 32'h0001_0000;
    bus.angle = 32'h2D00_0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midrst_done", {31'd0, bus.done}, 32'd0);
    check_eq("midrst_x", bus.x, 32'd0);
    check_eq("midrst_y", bus.y, 32'd0);
    extra_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check_eq("midrst_no_done", extra_done, 32'd0);

    // normal operation after the reset
    run_op(32'h0001_0000, 32'h7800_0000, 0, 0, 0, cyc, busy_cnt);
    check_eq("postrst_latency", cyc, 32'd26);
    check_near("postrst_x", bus.x, 32'hFFFF_8000);
    check_near("postrst_y", bus.y, 32'h0000_DDB4);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pol2rec_iter.md
Name: pol2rec_iter

Overview:
Iterative CORDIC converter in rotation mode. It turns a polar operand (modulus 16Q16, angle in degrees 8Q24) back into rectangular real/imaginary parts (16Q16). It is the inverse of the rec2pol path in the complex-arithmetic datapath: results computed in polar form (after complex multiply/divide) are returned to rectangular form for output. A start/busy/done handshake lets the top-level control FSM sequence it.

Parameters:
N_ITER, 24, number of CORDIC micro-rotations (range 16..30)
GUARD, 2, extra MSBs on internal x/y datapath to absorb gain growth
INV_GAIN, 32'h4DBA76D4, 1/K = 0.6072529350 in unsigned 1Q31, for the N_ITER≥16 gain

Ports:
clock     in   1   system clock, rising edge
reset     in   1   synchronous, active-high
enable    in   1   clock enable; when low the FSM and all registers hold
start     in   1   request; sampled in IDLE when enable=1
mod       in   32  modulus, signed 16Q16
angle     in   32  angle in degrees, signed 8Q24; valid range [-128.0, +128.0)
busy      out  1   high from the cycle after start is accepted until done
done      out  1   one-cycle pulse; x/y valid from this cycle onward
x         out  32  real part, signed 16Q16
y         out  32  imaginary part, signed 16Q16

Behaviour:
- Reset: state=IDLE; busy=0, done=0, x=0, y=0; all internal registers cleared. Reset wins over enable and start.
- All state changes require enable=1. enable=0 freezes state, the iteration counter and outputs, and extends latency by the number of stalled cycles.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE: when start=1, capture mod and angle, go to LOAD, set busy=1.
- LOAD, prescale and quadrant fold:
  - m' = (mod * INV_GAIN) >>> 31, signed 64-bit product truncated toward -inf.
  - If angle > +90.0 (0x5A000000): x0=0, y0=+m', z0=angle-90.0.
  - Else if angle < -90.0: x0=0, y0=-m', z0=angle+90.0.
  - Otherwise: x0=m', y0=0, z0=angle.
  - Set i=0 and go to ITER.
- ITER, one micro-rotation per enabled cycle:
  - d = (z ≥ 0) ? +1 : -1.
  - x ← x - d*(y>>>i); y ← y + d*(x>>>i); z ← z - d*ATAN[i].
  - Both updates use the pre-update x and y.
  - i increments; after i = N_ITER-1, go to DONE.
- DONE:
  - x and y outputs take the internal values, saturated to signed 32 bits.
  - done=1 for exactly this cycle; busy=0; then return to IDLE.
- Latency: start accepted at cycle T gives done at T + N_ITER + 2, absent stalls.
- x/y hold their last result until the next DONE or reset.
- start while busy is ignored; no queuing. start in the DONE cycle is also ignored; it is accepted in the next IDLE cycle.
- Internal x/y width is 32+GUARD. z is 32-bit signed 8Q24. Shifts are arithmetic.
- Accuracy: |error| ≤ 8 LSB (16Q16) for |mod| ≤ 1024.0 with N_ITER=24.
- Negative mod is not special-cased; it yields the point rotated by 180°.
- Angle exactly ±90.0 uses the unfolded path.
- Reset asserted mid-operation returns the block to IDLE within one cycle, with no done pulse.

Decomposition:
- Shared package cordic_pkg:
  - ATAN table constants in 8Q24 degrees: ATAN[0]=0x2D000000, ATAN[1]=0x1A90A732, … (30 entries).
  - Constants DEG90=0x5A000000 and INV_GAIN.
  - State enum.
- Sub-module cordic_atan_rom: combinational index→atan lookup, shared with rec2pol.
- The iteration datapath stays inline.

Test Plan:
- mod=0x00010000, angle=0 → x≈0x00010000, y≈0 (±8 LSB); done exactly 26 cycles after start; busy high 25 cycles.
- mod=0x00020000, angle=0x5A000000 (90°) → x≈0, y≈0x00020000; angle=0xA6000000 (-90°) → y≈0xFFFE0000.
- mod=0x00010000, angle=0x2D000000 (45°) → x≈y≈0x0000B505.
- mod=0x00010000, angle=0x78000000 (120°, folded path) → x≈0xFFFF8000, y≈0x0000DDB4.
- Hold enable=0 for 5 cycles mid-ITER → done at cycle 31, result identical; pulse start while busy → ignored, single done.
- Assert reset at cycle 10 of ITER → busy=0, done never pulses, x=y=0; next start after reset completes normally.
